// File: rtl/cnn_roi_downscaler.sv
// rtl/cnn_roi_downscaler.sv - streaming ROI box-sum downscaler writing a padded image to the LeNet buffer
module cnn_roi_downscaler #(
    parameter int WIDTH            = 640,
    parameter int HEIGHT           = 480,
    parameter int REC_WIDTH        = 8,
    parameter int REC_HEIGHT       = 8,
    parameter int CNN_INPUT_WIDTH  = 28,
    parameter int CNN_INPUT_HEIGHT = 28,
    parameter int CNN_INPUT_PAD    = 2,
    parameter int CAM_D_SIZE       = 8,
    parameter int THRESHOLD        = 'h1800,
    parameter int PAD_VALUE        = 0,
    localparam int OUT_W  = CNN_INPUT_WIDTH + 2*CNN_INPUT_PAD,
    localparam int OUT_H  = CNN_INPUT_HEIGHT + 2*CNN_INPUT_PAD,
    localparam int ADDR_W = $clog2(OUT_W*OUT_H)
) (
    input  logic                  clk24,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  mode,
    input  logic                  invert,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [CAM_D_SIZE-1:0] pix_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [CAM_D_SIZE-1:0] wr_data,
    output logic                  busy,
    output logic                  data_ready,
    input  logic                  data_ack
);

    localparam int ROI_W      = CNN_INPUT_WIDTH*REC_WIDTH;
    localparam int ROI_H      = CNN_INPUT_HEIGHT*REC_HEIGHT;
    localparam int X0         = (WIDTH-ROI_W)/2;
    localparam int Y0         = (HEIGHT-ROI_H)/2;
    localparam int SHIFT      = $clog2(REC_WIDTH*REC_HEIGHT);
    localparam int ACC_D_SIZE = SHIFT + CAM_D_SIZE;
    localparam int NPIX       = OUT_W*OUT_H;
    localparam int XW         = $clog2(WIDTH) + 1;
    localparam int YW         = $clog2(HEIGHT) + 1;
    localparam int LXW        = $clog2(REC_WIDTH);
    localparam int LYW        = $clog2(REC_HEIGHT);
    localparam int BXW        = (CNN_INPUT_WIDTH > 1) ? $clog2(CNN_INPUT_WIDTH) : 1;
    localparam int BYW        = (CNN_INPUT_HEIGHT > 1) ? $clog2(CNN_INPUT_HEIGHT) : 1;
    localparam int CW         = $clog2(OUT_W) + 1;
    localparam int RW         = $clog2(OUT_H) + 1;

    if (WIDTH < ROI_W || HEIGHT < ROI_H) begin : g_roi_check
        $error("cnn_roi_downscaler: ROI does not fit inside the frame");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, PAD_FILL, DONE} state_t;

    state_t                state;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic                  mode_q;
    logic                  invert_q;
    logic [ACC_D_SIZE-1:0] acc [CNN_INPUT_WIDTH];
    logic [ADDR_W-1:0]     pf_addr;
    logic [RW-1:0]         pf_row;
    logic [CW-1:0]         pf_col;

    logic                  frame_start;
    logic [XW-1:0]         rx;
    logic [YW-1:0]         ry;
    logic                  in_roi;
    logic                  blk_done;
    logic                  last_roi;
    logic [BXW-1:0]        bx;
    logic [BYW-1:0]        by;
    logic [ACC_D_SIZE-1:0] acc_sum;
    logic [CAM_D_SIZE-1:0] blk_pix;
    logic [ADDR_W-1:0]     blk_addr;
    logic                  pf_border;

    // A restart sof inside CAPTURE is treated exactly like a fresh start.
    assign frame_start = sof && ((state == IDLE && arm) || state == CAPTURE);

    assign rx       = x_cnt - XW'(X0);
    assign ry       = y_cnt - YW'(Y0);
    assign in_roi   = (x_cnt >= XW'(X0)) && (x_cnt < XW'(X0 + ROI_W)) &&
                      (y_cnt >= YW'(Y0)) && (y_cnt < YW'(Y0 + ROI_H));
    assign blk_done = in_roi &&
                      ((rx & XW'(REC_WIDTH-1))  == XW'(REC_WIDTH-1)) &&
                      ((ry & YW'(REC_HEIGHT-1)) == YW'(REC_HEIGHT-1));
    assign last_roi = in_roi && (x_cnt == XW'(X0 + ROI_W - 1)) && (y_cnt == YW'(Y0 + ROI_H - 1));
    assign bx       = BXW'(rx >> LXW);
    assign by       = BYW'(ry >> LYW);
    assign acc_sum  = acc[bx] + ACC_D_SIZE'(pix_data);
    assign blk_addr = ADDR_W'((int'(by) + CNN_INPUT_PAD) * OUT_W + int'(bx) + CNN_INPUT_PAD);

    always_comb begin
        if (mode_q) begin
            blk_pix = CAM_D_SIZE'(acc_sum >> SHIFT);
        end else begin
            blk_pix = (32'(acc_sum) >= 32'(THRESHOLD)) ? '1 : '0;
        end
        if (invert_q) begin
            blk_pix = ~blk_pix;
        end
    end

    assign pf_border = (pf_row < RW'(CNN_INPUT_PAD)) || (pf_row >= RW'(CNN_INPUT_PAD + CNN_INPUT_HEIGHT)) ||
                       (pf_col < CW'(CNN_INPUT_PAD)) || (pf_col >= CW'(CNN_INPUT_PAD + CNN_INPUT_WIDTH));

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            mode_q     <= 1'b0;
            invert_q   <= 1'b0;
            pf_addr    <= '0;
            pf_row     <= '0;
            pf_col     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
            for (int i = 0; i < CNN_INPUT_WIDTH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            wr_en <= 1'b0;
            if (frame_start) begin
                state    <= CAPTURE;
                busy     <= 1'b1;
                x_cnt    <= '0;
                y_cnt    <= '0;
                mode_q   <= mode;
                invert_q <= invert;
                for (int i = 0; i < CNN_INPUT_WIDTH; i++) begin
                    acc[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    CAPTURE: begin
                        if (pix_valid && (y_cnt < YW'(HEIGHT))) begin
                            if (x_cnt == XW'(WIDTH-1)) begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + 1'b1;
                            end else begin
                                x_cnt <= x_cnt + 1'b1;
                            end
                            if (in_roi) begin
                                if (blk_done) begin
                                    acc[bx] <= '0;
                                    wr_en   <= 1'b1;
                                    wr_addr <= blk_addr;
                                    wr_data <= blk_pix;
                                end else begin
                                    acc[bx] <= acc_sum;
                                end
                                if (last_roi) begin
                                    state   <= PAD_FILL;
                                    pf_addr <= '0;
                                    pf_row  <= '0;
                                    pf_col  <= '0;
                                end
                            end
                        end
                    end
                    PAD_FILL: begin
                        wr_en   <= pf_border;
                        wr_addr <= pf_addr;
                        wr_data <= CAM_D_SIZE'(PAD_VALUE);
                        if (pf_addr == ADDR_W'(NPIX-1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            pf_addr <= pf_addr + 1'b1;
                            if (pf_col == CW'(OUT_W-1)) begin
                                pf_col <= '0;
                                pf_row <= pf_row + 1'b1;
                            end else begin
                                pf_col <= pf_col + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // The ack is honoured only once the consumer can have seen data_ready.
                        if (data_ready && data_ack) begin
                            data_ready <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            data_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_roi_downscaler.sv
// tb/tb_cnn_roi_downscaler.sv - self-checking bench for cnn_roi_downscaler
module tb_cnn_roi_downscaler;

    localparam int W    = 64;
    localparam int H    = 48;
    localparam int OW   = 12;
    localparam int NPIX = OW*OW;
    localparam int X0   = 24;
    localparam int Y0   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       mode = 1'b0;
    logic       invert = 1'b0;
    logic       sof = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic       data_ack = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       data_ready;

    int asserts = 0;
    int fails = 0;

    logic [7:0] pix [H][W];
    logic [7:0] mem [NPIX];
    int         written [NPIX];
    int         int_wr, pad_wr, bad_wr, dr_rise;
    logic       dr_prev = 1'b0;
    int         toggle_row = -1;

    cnn_roi_downscaler #(
        .WIDTH(64), .HEIGHT(48), .REC_WIDTH(2), .REC_HEIGHT(2),
        .CNN_INPUT_WIDTH(8), .CNN_INPUT_HEIGHT(8), .CNN_INPUT_PAD(2),
        .CAM_D_SIZE(8), .THRESHOLD(400), .PAD_VALUE(0)
    ) dut (
        .clk24(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .invert(invert),
        .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .data_ready(data_ready), .data_ack(data_ack)
    );

    always #5 clk = ~clk;

    function automatic bit is_border(input int a);
        int r, c;
        r = a / OW;
        c = a % OW;
        return (r < 2) || (r >= 10) || (c < 2) || (c >= 10);
    endfunction

    // Expected buffer content: 2x2 box sum of the centred 16x16 ROI, 2-pixel zero border.
    function automatic logic [7:0] ref_pix(input int a, input bit md, input bit inv);
        int r, c, sum;
        logic [7:0] v;
        if (is_border(a)) return 8'd0;
        r = a / OW - 2;
        c = a % OW - 2;
        sum = 0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 2; i++)
                sum += int'(pix[Y0 + 2*r + j][X0 + 2*c + i]);
        v = md ? 8'(sum / 4) : ((sum >= 400) ? 8'hFF : 8'h00);
        return inv ? ~v : v;
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            if (int'(wr_addr) < NPIX) begin
                mem[wr_addr] = wr_data;
                written[wr_addr]++;
                if (is_border(int'(wr_addr))) pad_wr++;
                else int_wr++;
            end else begin
                bad_wr++;
            end
        end
        if (data_ready && !dr_prev) dr_rise++;
        dr_prev = data_ready;
    end

    task automatic clear_mon();
        for (int a = 0; a < NPIX; a++) begin
            mem[a] = 8'hxx;
            written[a] = 0;
        end
        int_wr = 0; pad_wr = 0; bad_wr = 0; dr_rise = 0;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = v;
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = 8'(x);
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_frame(input int nrows);
        @(posedge clk); #1 sof = 1'b1;
        @(posedge clk); #1 sof = 1'b0;
        for (int y = 0; y < nrows; y++) begin
            for (int x = 0; x < W; x++) begin
                while ($urandom_range(0, 7) == 0) begin
                    pix_valid = 1'b0;
                    @(posedge clk); #1;
                end
                if (x == 0 && y == toggle_row) mode = ~mode;
                pix_valid = 1'b1;
                pix_data  = pix[y][x];
                @(posedge clk); #1;
            end
        end
        if (nrows == H) begin
            for (int k = 0; k < 5; k++) begin
                pix_valid = 1'b1;
                pix_data  = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!data_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = data_ready;
    endtask

    task automatic do_ack();
        @(posedge clk); #1 data_ack = 1'b1;
        @(posedge clk); #1 data_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        asserts++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
        asserts++; if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin
            fails++; $display("FAIL reset_wr_bus addr=%h data=%h exp=0/0", wr_addr, wr_data);
        end
    endtask

    task automatic test_arm_low();
        arm = 1'b0;
        fill_const(200);
        clear_mon();
        send_frame(H);
        repeat (200) @(negedge clk);
        asserts++; if (int_wr + pad_wr + bad_wr !== 0) begin fails++; $display("FAIL armlow_writes got=%0d exp=0", int_wr + pad_wr + bad_wr); end
        asserts++; if (data_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL armlow_status ready=%b busy=%b exp=0/0", data_ready, busy);
        end
        arm = 1'b1;
    endtask

    task automatic test_solid_binary();
        bit ok;
        fill_const(200); mode = 1'b0; invert = 1'b0; arm = 1'b1;
        clear_mon();
        send_frame(H);
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t1_ready got=%b exp=1", data_ready); end
        for (int a = 0; a < NPIX; a++) begin
            asserts++;
            if (mem[a] !== ref_pix(a, 1'b0, 1'b0)) begin fails++; $display("FAIL t1_img addr=%0d got=%h exp=%h", a, mem[a], ref_pix(a, 1'b0, 1'b0)); end
        end
        asserts++; if (int_wr !== 64) begin fails++; $display("FAIL t1_int_writes got=%0d exp=64", int_wr); end
        asserts++; if (pad_wr !== 80) begin fails++; $display("FAIL t1_pad_writes got=%0d exp=80", pad_wr); end
        asserts++; if (bad_wr !== 0) begin fails++; $display("FAIL t1_bad_addr got=%0d exp=0", bad_wr); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy_done got=%b exp=0", busy); end
        repeat (20) @(negedge clk);
        asserts++; if (data_ready !== 1'b1 || dr_rise !== 1) begin
            fails++; $display("FAIL t1_ready_hold ready=%b rises=%0d exp=1/1", data_ready, dr_rise);
        end
        do_ack();
        asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL t1_ack got=%b exp=0", data_ready); end
    endtask

    task automatic test_greyscale();
        bit ok;
        fill_const(90); mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            invert = k[0];
            clear_mon();
            send_frame(H);
            wait_ready(ok);
            asserts++; if (!ok) begin fails++; $display("FAIL t2_ready inv=%0d got=%b exp=1", k, data_ready); end
            for (int a = 0; a < NPIX; a++) begin
                asserts++;
                if (mem[a] !== ref_pix(a, 1'b1, k[0])) begin fails++; $display("FAIL t2_img inv=%0d addr=%0d got=%h exp=%h", k, a, mem[a], ref_pix(a, 1'b1, k[0])); end
            end
            do_ack();
        end
        invert = 1'b0;
    endtask

    task automatic test_ramp();
        bit ok;
        fill_ramp(); mode = 1'b1; invert = 1'b0;
        clear_mon();
        send_frame(H);
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t3_ready got=%b exp=1", data_ready); end
        for (int a = 0; a < NPIX; a++) begin
            asserts++;
            if (mem[a] !== ref_pix(a, 1'b1, 1'b0)) begin fails++; $display("FAIL t3_img addr=%0d got=%h exp=%h", a, mem[a], ref_pix(a, 1'b1, 1'b0)); end
        end
        asserts++; if (mem[2*OW + 2 + 7] !== 8'd38) begin fails++; $display("FAIL t3_last_col got=%0d exp=38", mem[2*OW + 2 + 7]); end
        do_ack();
    endtask

    task automatic test_random_frames();
        bit ok;
        bit md, inv;
        for (int k = 0; k < 2; k++) begin
            fill_random();
            md = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 1));
            mode = md; invert = inv;
            clear_mon();
            send_frame(H);
            wait_ready(ok);
            asserts++; if (!ok) begin fails++; $display("FAIL rnd_ready got=%b exp=1", data_ready); end
            for (int a = 0; a < NPIX; a++) begin
                asserts++;
                if (mem[a] !== ref_pix(a, md, inv)) begin fails++; $display("FAIL rnd_img md=%0d inv=%0d addr=%0d got=%h exp=%h", md, inv, a, mem[a], ref_pix(a, md, inv)); end
            end
            do_ack();
        end
        invert = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_const(50); mode = 1'b1; invert = 1'b0;
        clear_mon();
        send_frame(H);
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t4_ready got=%b exp=1", data_ready); end
        fill_const(123);
        clear_mon();
        send_frame(H);
        repeat (200) @(negedge clk);
        asserts++; if (int_wr + pad_wr + bad_wr !== 0) begin fails++; $display("FAIL t4_blocked_writes got=%0d exp=0", int_wr + pad_wr + bad_wr); end
        asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL t4_still_ready got=%b exp=1", data_ready); end
        do_ack();
        asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL t4_ack got=%b exp=0", data_ready); end
        clear_mon();
        send_frame(H);
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t4_next_ready got=%b exp=1", data_ready); end
        for (int a = 0; a < NPIX; a++) begin
            asserts++;
            if (mem[a] !== ref_pix(a, 1'b1, 1'b0)) begin fails++; $display("FAIL t4_img addr=%0d got=%h exp=%h", a, mem[a], ref_pix(a, 1'b1, 1'b0)); end
        end
        do_ack();
    endtask

    task automatic test_restart();
        bit ok;
        int dup;
        fill_random(); mode = 1'b1; invert = 1'b0;
        send_frame(Y0 + 10);
        repeat (2) @(negedge clk);
        fill_random();
        clear_mon();
        toggle_row = 20;
        send_frame(H);
        toggle_row = -1;
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t5_ready got=%b exp=1", data_ready); end
        asserts++; if (int_wr !== 64) begin fails++; $display("FAIL t5_int_writes got=%0d exp=64", int_wr); end
        dup = 0;
        for (int a = 0; a < NPIX; a++)
            if (!is_border(a) && written[a] != 1) dup++;
        asserts++; if (dup !== 0) begin fails++; $display("FAIL t5_once_each got=%0d bad addrs exp=0", dup); end
        for (int a = 0; a < NPIX; a++) begin
            asserts++;
            if (mem[a] !== ref_pix(a, 1'b1, 1'b0)) begin fails++; $display("FAIL t5_img addr=%0d got=%h exp=%h", a, mem[a], ref_pix(a, 1'b1, 1'b0)); end
        end
        mode = 1'b1;
        do_ack();
    endtask

    task automatic test_async_reset();
        bit ok;
        fill_const(77); mode = 1'b1;
        send_frame(Y0 + 9);
        asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL t6_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        asserts++; if (wr_en !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b0) begin
            fails++; $display("FAIL t6_reset_now wr_en=%b busy=%b ready=%b exp=0/0/0", wr_en, busy, data_ready);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fill_const(200); mode = 1'b0; invert = 1'b0;
        clear_mon();
        send_frame(H);
        wait_ready(ok);
        asserts++; if (!ok) begin fails++; $display("FAIL t6_ready got=%b exp=1", data_ready); end
        asserts++; if (int_wr !== 64 || pad_wr !== 80) begin fails++; $display("FAIL t6_writes int=%0d pad=%0d exp=64/80", int_wr, pad_wr); end
        for (int a = 0; a < NPIX; a++) begin
            asserts++;
            if (mem[a] !== ref_pix(a, 1'b0, 1'b0)) begin fails++; $display("FAIL t6_img addr=%0d got=%h exp=%h", a, mem[a], ref_pix(a, 1'b0, 1'b0)); end
        end
        do_ack();
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        test_arm_low();
        test_solid_binary();
        test_greyscale();
        test_ramp();
        test_random_frames();
        test_back_to_back();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
